sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
//   Front-end stage for the 2-to-4 LED decoder. Takes raw, asynchronous, bouncing slide-switch
//   pins and produces a clean, clock-synchronous switch code for the decoder.
//   - Synchronises each bit to clk.
//   - Debounces each bit independently with a stable-time counter.
//   - Emits a one-cycle strobe whenever the debounced code changes.
//   - sw_db[1:0] drives the decoder select directly.
// PARAMETERS
//   WIDTH            2       number of switch bits debounced in parallel
//   SYNC_STAGES      2       flip-flops in each input synchroniser chain (>=2)
//   DEBOUNCE_CYCLES  120000  consecutive clk cycles a new level must hold before it is accepted
//                            (10 ms at 12 MHz); legal range >= 2
// PORTS
//   clk      input   1      single system clock; all logic on rising edge
//   rst_n    input   1      reset, synchronous, active-low
//   sw_raw   input   WIDTH  raw switch pins, asynchronous to clk, may bounce
//   sw_db    output  WIDTH  debounced, synchronous switch code (feeds decoder select)
//   sw_stb   output  1      one-cycle pulse, high in the cycle sw_db takes a new value
//   busy     output  1      high while any bit's debounce counter is non-zero
// BEHAVIOUR
//   Clocking and reset
//   - One clock domain; reset is synchronous and active-low.
//   - rst_n=0 at a rising edge clears every register: sync chains, counters, sw_db, sw_stb, busy.
//   - Reset asserted mid-count discards the pending change; no strobe is generated.
//   - After rst_n rises, a switch already at 1 is accepted after the normal latency, with sw_stb.
//   Synchroniser
//   - Per bit, a SYNC_STAGES-deep chain; s = last stage.
//   - sw_raw is never used combinationally.
//   Debounce, per bit i
//   - Each bit has counter cnt_i, width $clog2(DEBOUNCE_CYCLES).
//   - s == sw_db[i]: cnt_i <= 0. Any bounce shorter than DEBOUNCE_CYCLES is discarded with no
//     output change.
//   - s != sw_db[i] and cnt_i < DEBOUNCE_CYCLES-1: cnt_i <= cnt_i + 1.
//   - s != sw_db[i] and cnt_i == DEBOUNCE_CYCLES-1: sw_db[i] <= s and cnt_i <= 0.
//     This event is the per-bit "change".
//   - cnt_i never wraps. The terminal count is the only exit other than a match.
//   Latency
//   - A clean step on sw_raw[i] changes sw_db[i] on rising edge number SYNC_STAGES+DEBOUNCE_CYCLES.
//   - Edge 1 is the first edge that samples the new level.
//   Strobe
//   - sw_stb is registered: high for exactly one cycle, coincident with the first cycle of the
//     new sw_db value.
//   - sw_stb = OR of the per-bit change events. Two bits changing on the same edge give ONE pulse.
//   - Bits changing on different edges give separate pulses. The decoder may see intermediate codes.
//   busy
//   - Registered OR of (next cnt_i != 0) over all bits.
//   - Low in every cycle where the output is settled.
//   Per-bit state (2 states)
//   - STABLE (cnt_i == 0, s == sw_db[i]): on s != sw_db[i], go to COUNTING.
//   - COUNTING: on s == sw_db[i], return to STABLE with no output change.
//     On the terminal count, update sw_db[i], pulse sw_stb, return to STABLE.
// STRUCTURE
//   Shared package board_pkg
//   - CLK_HZ = 12_000_000 and DEBOUNCE_MS = 10.
//   - Derived localparam DEBOUNCE_CYCLES = CLK_HZ/1000*DEBOUNCE_MS.
//   - Both this block and the board top take the value from there.
//   Sub-module debounce_bit
//   - Contains the sync chain, counter and compare for one bit.
//   - Outputs: db, chg.
//   - sw_debounce generates WIDTH instances, ORs the chg outputs into sw_stb, and ORs the
//     counter-nonzero signals into busy.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//   1. Reset
//      - Stimulus: rst_n=0 for 3 edges with sw_raw=2'b11.
//      - Response: sw_db=0, sw_stb=0, busy=0 throughout.
//      - After release, sw_db=2'b11 on edge 6 with a single sw_stb pulse.
//   2. Clean step
//      - Stimulus: sw_raw 00->01, held.
//      - Response: sw_db=2'b01 exactly on edge 6; sw_stb high 1 cycle; busy high during counting.
//   3. Bounce rejection
//      - Stimulus: sw_raw[1] toggles 0/1 every 2 cycles for 20 cycles, then returns to 0.
//      - Response: sw_db stays 00; sw_stb never pulses.
//   4. Bounce then settle
//      - Stimulus: 3 short glitches, then sw_raw=2'b10 held.
//      - Response: sw_db=2'b10 on edge 6 after the last transition; exactly one pulse.
//   5. Simultaneous change
//      - Stimulus: sw_raw 01->10 on one edge.
//      - Response: sw_db jumps 01->10 in one cycle, with no 00/11 intermediate; one sw_stb pulse.
//   6. Mid-count reset
//      - Stimulus: step to 11; assert rst_n=0 at edge 4.
//      - Response: sw_db=00, no pulse, busy=0. After release, the normal latency restarts from zero.

Source files
------------

// File: rtl/board_pkg.sv
// Board-wide constants shared by the switch front end and the board top.
package board_pkg;

    localparam int CLK_HZ          = 12_000_000;
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

    // Per-bit debounce states: idle and matching, or timing a candidate level
    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    // Counter width for a stable-time count; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, stable-time counter and accept logic.
module debounce_bit
    import board_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = board_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic db_o,
    output logic chg_o,
    output logic busy_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   db_q;
    logic                   db_d;
    logic                   chg;
    logic [0:0]             state;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser; only the last stage is ever used
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Time how long the synchronised level has disagreed with the accepted level
    always_comb begin
        state = (cnt_q == '0) ? ST_STABLE : ST_COUNTING;
        cnt_d = cnt_q;
        db_d  = db_q;
        chg   = 1'b0;
        case (state)
            ST_STABLE: begin
                if (s != db_q) begin
                    cnt_d = CNT_W'(1);
                end
            end
            ST_COUNTING: begin
                if (s == db_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    db_d  = s;
                    cnt_d = '0;
                    chg   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Commit the counter and the accepted level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_o   = db_q;
    assign chg_o  = chg;
    assign busy_o = (cnt_d != '0);

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch front end: per-bit debouncers plus a shared change strobe and busy flag.
module sw_debounce
    import board_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = board_pkg::DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic             sw_stb,
    output logic             busy
);

    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] cnt_nz;
    logic             stb_q;
    logic             stb_d;
    logic             busy_q;
    logic             busy_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (sw_raw[i]),
            .db_o   (sw_db[i]),
            .chg_o  (chg[i]),
            .busy_o (cnt_nz[i])
        );
    end

    // Simultaneous bit changes merge into a single strobe
    always_comb begin
        stb_d  = |chg;
        busy_d = |cnt_nz;
    end

    // Register strobe and busy so they line up with the new switch code
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            stb_q  <= stb_d;
            busy_q <= busy_d;
        end
    end

    assign sw_stb = stb_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with a short debounce time.
module tb_sw_debounce;

    localparam int LAT = 2 + 4;

    typedef struct {
        logic [1:0] db;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw_raw;
    logic [1:0] sw_db;
    logic       sw_stb;
    logic       busy;

    exp_t expQ[$];
    int   cyc;
    int   compared;
    int   mismatched;
    int   t0;
    logic [1:0] prevDb;
    logic       prevRst;

    sw_debounce #(
        .WIDTH           (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_raw (sw_raw),
        .sw_db  (sw_db),
        .sw_stb (sw_stb),
        .busy   (busy)
    );

    // Free-running clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: every strobe pops the next expected code and its expected edge
    always @(negedge clk) begin
        if (sw_stb === 1'b1) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL strobe: unexpected pulse at edge %0d, sw_db=%b", cyc, sw_db);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (sw_db !== e.db || cyc != e.cyc) begin
                    mismatched++;
                    $display("[TB] FAIL strobe: got sw_db=%b at edge %0d, want %b at edge %0d",
                             sw_db, cyc, e.db, e.cyc);
                end
            end
        end
        if (rst_n === 1'b1 && prevRst === 1'b1 && sw_db !== prevDb) begin
            compared++;
            if (sw_stb !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL dbchange: sw_db %b->%b without strobe at edge %0d",
                         prevDb, sw_db, cyc);
            end
        end
        prevDb  = sw_db;
        prevRst = rst_n;
    end

    // Drive a new switch pattern after a falling edge; optionally predict its acceptance
    task automatic applyStimulus(input logic [1:0] v, input bit expectChange);
        exp_t e;
        @(negedge clk);
        sw_raw = v;
        t0     = cyc;
        if (expectChange) begin
            e.db  = v;
            e.cyc = t0 + LAT;
            expQ.push_back(e);
        end
    endtask

    // Compare a sampled output against its hand-computed value
    task automatic checkOutput(input string name, input logic [1:0] got, input logic [1:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b want %b at edge %0d", name, got, want, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        cyc        = 0;
        compared   = 0;
        mismatched = 0;
        prevDb     = 2'b00;
        prevRst    = 1'b0;
        rst_n      = 1'b0;
        sw_raw     = 2'b11;

        // 1. Reset held for three edges with switches high
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_db", sw_db, 2'b00);
            checkOutput("rst_stb", {1'b0, sw_stb}, 2'b00);
            checkOutput("rst_busy", {1'b0, busy}, 2'b00);
        end
        rst_n = 1'b1;
        t0    = cyc;
        e.db  = 2'b11;
        e.cyc = t0 + LAT;
        expQ.push_back(e);
        waitCycles(LAT + 3);
        checkOutput("post_rst_db", sw_db, 2'b11);

        // 2. Return to 00, then a clean step to 01 with busy profile
        applyStimulus(2'b00, 1'b1);
        waitCycles(LAT + 3);
        applyStimulus(2'b01, 1'b1);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            checkOutput("step_busy", {1'b0, busy}, (k >= 3 && k <= 5) ? 2'b01 : 2'b00);
        end
        checkOutput("step_db", sw_db, 2'b01);

        // 3. Bounce on bit 1 from a settled 00 is rejected
        applyStimulus(2'b00, 1'b1);
        waitCycles(LAT + 3);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b10, 1'b0);
            waitCycles(1);
            applyStimulus(2'b00, 1'b0);
            waitCycles(1);
        end
        waitCycles(LAT + 2);
        checkOutput("bounce_db", sw_db, 2'b00);
        checkOutput("bounce_busy", {1'b0, busy}, 2'b00);

        // 4. Three single-cycle glitches, then settle at 10
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b10, 1'b0);
            applyStimulus(2'b00, 1'b0);
        end
        applyStimulus(2'b10, 1'b1);
        waitCycles(LAT + 3);
        checkOutput("settle_db", sw_db, 2'b10);

        // 5. Both bits change on one edge: 10->01, then 01->10
        applyStimulus(2'b01, 1'b1);
        waitCycles(LAT + 3);
        applyStimulus(2'b10, 1'b1);
        waitCycles(LAT + 3);
        checkOutput("simul_db", sw_db, 2'b10);

        // 6. Step to 11, reset sampled on edge 4 of the count
        applyStimulus(2'b11, 1'b0);
        waitCycles(3);
        checkOutput("mid_busy", {1'b0, busy}, 2'b01);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("mid_rst_db", sw_db, 2'b00);
            checkOutput("mid_rst_stb", {1'b0, sw_stb}, 2'b00);
            checkOutput("mid_rst_busy", {1'b0, busy}, 2'b00);
        end
        rst_n = 1'b1;
        t0    = cyc;
        e.db  = 2'b11;
        e.cyc = t0 + LAT;
        expQ.push_back(e);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            checkOutput("restart_busy", {1'b0, busy}, (k >= 3 && k <= 5) ? 2'b01 : 2'b00);
        end
        checkOutput("restart_db", sw_db, 2'b11);

        waitCycles(4);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expected strobes never seen, want 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
